// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmitter and the keyboard receiver.
//   ps2_tx_state_t : host transmitter FSM states
//   PS2_CMD_*      : common host-to-device command bytes
//   PS2_RSP_ACK    : device acknowledge byte
//   odd_parity()   : parity bit that makes the 9-bit data+parity field odd
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StSend,
    StWaitIdle,
    StDone
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 pin conditioning: 2-FF synchronizers for PS2_CLK and PS2_DAT plus a
// falling-edge detector on the synchronized clock. Shared with the receiver.
//   clk, reset   : system clock, synchronous active-high reset
//   ps2_clk_i    : raw PS2_CLK pin level (asynchronous)
//   ps2_data_i   : raw PS2_DAT pin level (asynchronous)
//   clk_sync_o   : synchronized clock level
//   data_sync_o  : synchronized data level
//   fall_o       : one-cycle pulse on a 1->0 transition of clk_sync_o
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync_o,
  output logic data_sync_o,
  output logic fall_o
);

  logic [1:0] clk_meta_q;
  logic [1:0] data_meta_q;
  logic       clk_prev_q;

  // Idle bus is high; resetting to 1 avoids a spurious fall after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q  <= 2'b11;
      data_meta_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_meta_q  <= {clk_meta_q[0], ps2_clk_i};
      data_meta_q <= {data_meta_q[0], ps2_data_i};
      clk_prev_q  <= clk_meta_q[1];
    end
  end

  assign clk_sync_o  = clk_meta_q[1];
  assign data_sync_o = data_meta_q[1];
  assign fall_o      = clk_prev_q & ~clk_meta_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, start bit, 8 data bits LSB
// first, odd parity, stop bit, then samples the device acknowledge.
// Optional watchdog: define PS2_HOST_TX_TIMEOUT_EN to abort a transaction
// TIMEOUT_CYCLES cycles after the request-to-send; otherwise timeout_err is 0.
//   clk, reset          : system clock, synchronous active-high reset
//   tx_data, tx_valid   : command byte and request (taken when tx_ready)
//   tx_ready            : high only when idle
//   ps2_clk_in/data_in  : raw pin levels
//   ps2_clk_oe/data_oe  : 1 = pull the pin low, 0 = release
//   busy                : transaction in progress
//   done                : one-cycle end-of-transaction pulse
//   ack_err/timeout_err : one-cycle error pulses coincident with done
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);

  logic clk_sync, data_sync, fall;

  ps2_line_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_i   (ps2_clk_in),
    .ps2_data_i  (ps2_data_in),
    .clk_sync_o  (clk_sync),
    .data_sync_o (data_sync),
    .fall_o      (fall)
  );

  ps2_tx_state_t   state_q;
  logic [7:0]      data_q;
  logic            parity_q;
  logic [InhW-1:0] inh_cnt_q;
  logic [3:0]      bit_cnt_q;
  logic            ack_miss_q;
  logic            tx_ready_q, clk_oe_q, data_oe_q, busy_q, done_q, ack_err_q;
  logic            timeout;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] wd_q;
  logic            tmo_err_q;

  // Held at zero until the request-to-send starts, so it counts from REQ entry.
  always_ff @(posedge clk) begin
    if (reset || state_q == StIdle || state_q == StInhibit) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end

  // DONE is excluded: it already ends the transaction with its own done pulse.
  assign timeout = (wd_q == TmoLast) &&
                   (state_q == StReq || state_q == StSend || state_q == StWaitIdle);
  assign timeout_err = tmo_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      data_q     <= '0;
      parity_q   <= 1'b0;
      inh_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      ack_miss_q <= 1'b0;
      tx_ready_q <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      tmo_err_q  <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      tmo_err_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (tx_valid && tx_ready_q) begin
            data_q     <= tx_data;
            parity_q   <= odd_parity(tx_data);
            inh_cnt_q  <= '0;
            clk_oe_q   <= 1'b1;
            busy_q     <= 1'b1;
            tx_ready_q <= 1'b0;
            state_q    <= StInhibit;
          end else begin
            tx_ready_q <= 1'b1;
          end
        end
        StInhibit: begin
          if (inh_cnt_q == InhLast) begin
            data_oe_q <= 1'b1;  // start bit overlaps the last inhibit cycle
            state_q   <= StReq;
          end else begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
          end
        end
        StReq: begin
          clk_oe_q  <= 1'b0;
          bit_cnt_q <= '0;
          state_q   <= StSend;
        end
        StSend: begin
          if (fall) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            // bit_cnt_q holds the number of falls seen before this one
            if (bit_cnt_q < 4'd8) begin
              data_oe_q <= ~data_q[bit_cnt_q[2:0]];
            end else if (bit_cnt_q == 4'd8) begin
              data_oe_q <= ~parity_q;
            end else if (bit_cnt_q == 4'd9) begin
              data_oe_q <= 1'b0;
            end else begin
              ack_miss_q <= data_sync;
              state_q    <= StWaitIdle;
            end
          end
        end
        StWaitIdle: begin
          if (clk_sync && data_sync) begin
            done_q    <= 1'b1;
            ack_err_q <= ack_miss_q;
            state_q   <= StDone;
          end
        end
        StDone: begin
          busy_q     <= 1'b0;
          tx_ready_q <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
      // Takes priority over any simultaneous fall handling above.
      if (timeout) begin
        state_q    <= StIdle;
        clk_oe_q   <= 1'b0;
        data_oe_q  <= 1'b0;
        busy_q     <= 1'b0;
        tx_ready_q <= 1'b1;
        done_q     <= 1'b1;
        ack_err_q  <= 1'b0;
        tmo_err_q  <= 1'b1;
      end
`endif
    end
  end

  assign tx_ready    = tx_ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int unsigned Inh  = 20;
  localparam int unsigned Tmo  = 1000;
  localparam int          Half = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err;
  logic       ps2_clk_in, ps2_data_in;

  // Open-collector bus with pull-ups
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (Inh),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   wide_cnt = 0;
  logic done_d = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (done === 1'b1 && done_d === 1'b1) wide_cnt <= wide_cnt + 1;
    done_d <= done;
  end

  // Model: expected data_oe after falls 1..10 (bit i = after fall i+1).
  function automatic logic [9:0] exp_oe(input logic [7:0] d);
    logic [9:0] v;
    int ones = 0;
    for (int i = 0; i < 8; i++) begin
      v[i] = d[i] ? 1'b0 : 1'b1;
      if (d[i]) ones++;
    end
    v[8] = (ones % 2 == 0) ? 1'b0 : 1'b1;  // parity bit is 1 when ones is even
    v[9] = 1'b0;
    return v;
  endfunction

  // Expected pin levels after falls 1..10: data, parity, stop.
  function automatic logic [9:0] exp_pin(input logic [7:0] d);
    return ~exp_oe(d);
  endfunction

  task automatic handshake(input logic [7:0] d);
    int c = 0;
    int first = 0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL ready_before_req: got %b want 1", tx_ready);
    end
    tx_data = d; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if ({ps2_clk_oe, busy, tx_ready, ps2_data_oe} !== 4'b1100) begin
      errors++;
      $display("FAIL handshake_latency: clk_oe,busy,ready,data_oe=%b want 1100",
               {ps2_clk_oe, busy, tx_ready, ps2_data_oe});
    end
    while (ps2_clk_oe === 1'b1 && c < 5000) begin
      c++;
      if (ps2_data_oe === 1'b1 && first == 0) first = c;
      @(negedge clk);
    end
    checks++;
    if (c != Inh + 1 || first != Inh + 1 || ps2_data_oe !== 1'b1) begin
      errors++;
      $display("FAIL inhibit_len: clk_oe cycles=%0d start at %0d data_oe=%b want %0d,%0d,1",
               c, first, ps2_data_oe, Inh + 1, Inh + 1);
    end
  endtask

  // Device clocks the frame. Stops after fall abort_after (clock left low) if nonzero.
  task automatic device_frame(input bit ack_ok, input int abort_after, input bit inject,
                              output logic [10:0] oe_after, output logic [10:0] pin);
    oe_after = '0; pin = '0;
    repeat (Half) @(negedge clk);
    for (int n = 1; n <= 11; n++) begin
      if (n == 11) begin
        dev_data_low = ack_ok;
        repeat (2) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      if (inject && n == 4) begin
        tx_data = 8'h55; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (Half - 1) @(negedge clk);
      end else begin
        repeat (Half) @(negedge clk);
      end
      oe_after[n-1] = ps2_data_oe;
      pin[n-1]      = ps2_data_in;
      if (n == abort_after) return;
      dev_clk_low = 1'b0;
      if (n == 11) dev_data_low = 1'b0;
      if (n < 11) repeat (Half) @(negedge clk);
    end
  endtask

  task automatic wait_done(input string name, input bit want_ack_err);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1 || ack_err !== want_ack_err || timeout_err !== 1'b0 ||
        ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: done=%b ack_err=%b tmo=%b oe=%b%b want 1 %b 0 00",
               name, done, ack_err, timeout_err, ps2_clk_oe, ps2_data_oe, want_ack_err);
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || done !== 1'b0 || ack_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done: ready=%b done=%b ack_err=%b busy=%b want 1 0 0 0",
               name, tx_ready, done, ack_err, busy);
    end
  endtask

  task automatic full_frame(input string name, input logic [7:0] d, input bit ack_ok,
                            input bit inject);
    logic [10:0] oe, pin;
    int dc0 = done_cnt;
    handshake(d);
    device_frame(ack_ok, 0, inject, oe, pin);
    checks++;
    if (oe[9:0] !== exp_oe(d)) begin
      errors++; $display("FAIL %s_data_oe: got %b want %b", name, oe[9:0], exp_oe(d));
    end
    checks++;
    if (pin[9:0] !== exp_pin(d)) begin
      errors++; $display("FAIL %s_pin_bits: got %b want %b", name, pin[9:0], exp_pin(d));
    end
    wait_done(name, ack_ok ? 1'b0 : 1'b1);
    checks++;
    if (done_cnt != dc0 + 1) begin
      errors++; $display("FAIL %s_done_count: got %0d want 1", name, done_cnt - dc0);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; tx_valid = 1'b1; tx_data = 8'hED;
    repeat (3) @(negedge clk);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_values: got %b want 000000",
               {ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err});
    end
    reset = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b clk_oe=%b want 1 0 0",
               tx_ready, busy, ps2_clk_oe);
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    int dc0 = done_cnt;
    handshake(8'($urandom));
`ifdef PS2_HOST_TX_TIMEOUT_EN
    // handshake returns one cycle after REQ entry
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != Tmo - 1 || timeout_err !== 1'b1 || ack_err !== 1'b0 ||
        ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL timeout: cycles after REQ=%0d tmo=%b ack=%b oe=%b%b want %0d 1 0 00",
               n + 1, timeout_err, ack_err, ps2_clk_oe, ps2_data_oe, Tmo);
    end
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || done !== 1'b0 || timeout_err !== 1'b0 || done_cnt != dc0 + 1) begin
      errors++;
      $display("FAIL timeout_after: ready=%b done=%b tmo=%b dones=%0d want 1 0 0 1",
               tx_ready, done, timeout_err, done_cnt - dc0);
    end
`else
    repeat (Tmo + 500) @(negedge clk);
    checks++;
    if (done_cnt != dc0 || busy !== 1'b1 || ps2_data_oe !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL no_watchdog_wait: dones=%0d busy=%b data_oe=%b tmo=%b want 0 1 1 0",
               done_cnt - dc0, busy, ps2_data_oe, timeout_err);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid_frame;
    logic [10:0] oe, pin;
    int dc0;
    handshake(8'hED);
    device_frame(1'b1, 5, 1'b0, oe, pin);
    dc0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: clk_oe,data_oe,busy,done=%b want 0000",
               {ps2_clk_oe, ps2_data_oe, busy, done});
    end
    reset = 1'b0; dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != dc0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_no_done: dones=%0d ready=%b want 0 1", done_cnt - dc0, tx_ready);
    end
    full_frame("after_reset_ff", 8'hFF, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d = 8'($urandom);
      bit ack = 1'($urandom_range(0, 1));
      full_frame("random", d, ack, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    full_frame("led_ed", 8'hED, 1'b1, 1'b0);
    full_frame("parity0_01", 8'h01, 1'b1, 1'b0);
    full_frame("ack_err", 8'hF4, 1'b0, 1'b0);
    test_timeout();
    test_reset_mid_frame();
    full_frame("ignore_valid", 8'hED, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
      errors++; $display("FAIL ignored_req_started: busy=%b clk_oe=%b want 0 0", busy, ps2_clk_oe);
    end
    test_random();
    checks++;
    if (wide_cnt != 0) begin
      errors++; $display("FAIL done_width: multi-cycle done pulses=%0d want 0", wide_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
